// File: rtl/mem_access_unit.sv
// mem_access_unit
//   CPU-side initiator for a data memory. Takes one load/store per request
//   handshake, drives the memory's address/mode/raw data/write-enable, waits
//   out the read latency and returns size-masked, sign/zero-extended load data
//   (or a plain ack for stores). Misaligned or illegal-size requests are
//   answered with resp_err=1 and never reach the memory.
// Ports
//   clock, reset                 : single clock, asynchronous active-high reset
//   req_valid/req_ready          : request handshake (ready only while idle)
//   req_write/size/signed/addr/wdata : request fields, latched on accept
//   resp_valid/resp_ready        : response handshake, response held until taken
//   resp_data/resp_err           : extended load data (0 for stores/errors), error flag
//   mem_raw_data/address/wren/mode : registered drive into the data memory
//   mem_q                        : memory read data, addressed item in low bits
module mem_access_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] mem_raw_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wren,
  output logic [1:0]            mem_mode,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  signed_q, signed_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [DATA_WIDTH-1:0] mem_raw_data_q, mem_raw_data_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic                  mem_wren_q, mem_wren_d;
  logic [1:0]            mem_mode_q, mem_mode_d;

  logic                  req_bad;
  logic [DATA_WIDTH-1:0] load_ext;

  // Size code 11 is illegal; halves need even addresses, words 4-byte aligned.
  assign req_bad = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b00 && req_addr[1:0] != 2'b00);

  // mem_mode_q doubles as the latched request size; it is held from ISSUE
  // through WAIT, so it is valid when mem_q is captured.
  always_comb begin
    load_ext = mem_q;
    case (mem_mode_q)
      2'b10:   load_ext = {{(DATA_WIDTH-8){signed_q & mem_q[7]}}, mem_q[7:0]};
      2'b01:   load_ext = {{(DATA_WIDTH-16){signed_q & mem_q[15]}}, mem_q[15:0]};
      default: load_ext = mem_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    write_d        = write_q;
    signed_d       = signed_q;
    req_ready_d    = req_ready_q;
    resp_valid_d   = resp_valid_q;
    resp_err_d     = resp_err_q;
    resp_data_d    = resp_data_q;
    mem_raw_data_d = mem_raw_data_q;
    mem_address_d  = mem_address_q;
    mem_wren_d     = mem_wren_q;
    mem_mode_d     = mem_mode_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (req_bad) begin
            // Rejected requests skip the memory entirely.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d        = S_ISSUE;
            write_d        = req_write;
            signed_d       = req_signed;
            mem_address_d  = req_addr;
            mem_mode_d     = req_size;
            mem_raw_data_d = req_wdata;
            mem_wren_d     = req_write;   // write strobe lives only in ISSUE
          end
        end
      end
      S_ISSUE: begin
        mem_wren_d = 1'b0;
        if (write_q) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = '0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = load_ext;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_data_d  = '0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        mem_wren_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_data_q    <= '0;
      mem_raw_data_q <= '0;
      mem_address_q  <= '0;
      mem_wren_q     <= 1'b0;
      mem_mode_q     <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      write_q        <= write_d;
      signed_q       <= signed_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_data_q    <= resp_data_d;
      mem_raw_data_q <= mem_raw_data_d;
      mem_address_q  <= mem_address_d;
      mem_wren_q     <= mem_wren_d;
      mem_mode_q     <= mem_mode_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_data    = resp_data_q;
  assign mem_raw_data = mem_raw_data_q;
  assign mem_address  = mem_address_q;
  assign mem_wren     = mem_wren_q;
  assign mem_mode     = mem_mode_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a byte-addressed memory stand-in
// for the MEM_LATENCY=1 instance, a table of directed vectors, randomized
// transactions checked against a byte-array reference, an abort-by-reset
// sequence and a MEM_LATENCY=3 instance for the latency corner.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- instance with MEM_LATENCY = 1 ----------------
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_wren;
  logic [31:0] resp_data, mem_raw_data, mem_address, mem_q;
  logic [1:0]  mem_mode;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut (
    .clock(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .mem_raw_data(mem_raw_data),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_mode(mem_mode),
    .mem_q(mem_q)
  );

  // ---------------- instance with MEM_LATENCY = 3 ----------------
  logic        req_valid_3 = 1'b0, req_signed_3 = 1'b0, resp_ready_3 = 1'b0;
  logic [1:0]  req_size_3 = 2'b00;
  logic [31:0] req_addr_3 = '0;
  logic        req_ready_3, resp_valid_3, resp_err_3, mem_wren_3;
  logic [31:0] resp_data_3, mem_raw_data_3, mem_address_3, mem_q_3;
  logic [1:0]  mem_mode_3;
  logic [31:0] pipe_3 [3];

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(3)) dut3 (
    .clock(clk), .reset(rst),
    .req_valid(req_valid_3), .req_ready(req_ready_3), .req_write(1'b0),
    .req_size(req_size_3), .req_signed(req_signed_3), .req_addr(req_addr_3),
    .req_wdata(32'h0), .resp_valid(resp_valid_3), .resp_ready(resp_ready_3),
    .resp_data(resp_data_3), .resp_err(resp_err_3), .mem_raw_data(mem_raw_data_3),
    .mem_address(mem_address_3), .mem_wren(mem_wren_3), .mem_mode(mem_mode_3),
    .mem_q(mem_q_3)
  );

  // Read-only memory pattern for the latency-3 instance: value depends on the
  // address, delivered three clocks after the address is presented.
  function automatic logic [31:0] pattern3(logic [31:0] a);
    return {8'h12, a[7:0], ~a[7:0], a[7:0] | 8'h80};
  endfunction

  always @(posedge clk) begin
    pipe_3[0] <= pattern3(mem_address_3);
    pipe_3[1] <= pipe_3[0];
    pipe_3[2] <= pipe_3[1];
  end
  assign mem_q_3 = pipe_3[2];

  // ---------------- data memory stand-in and reference ----------------
  logic [7:0] mem_bytes [256];   // what the DUT actually writes/reads
  logic [7:0] ref_mem   [256];   // what the bench expects memory to hold

  function automatic int nbytes(logic [1:0] sz);
    case (sz)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] rd_word(logic [7:0] a);
    return {mem_bytes[a + 8'd3], mem_bytes[a + 8'd2], mem_bytes[a + 8'd1], mem_bytes[a]};
  endfunction

  always @(posedge clk) begin
    if (mem_wren) begin
      for (int k = 0; k < 4; k++)
        if (k < nbytes(mem_mode))
          mem_bytes[8'(mem_address[7:0] + k)] <= mem_raw_data[8*k +: 8];
    end
    mem_q <= rd_word(mem_address[7:0]);
  end

  // Extension by arithmetic: keep the low n bytes, subtract 2^(8n) when signed
  // and the value lies in the upper half of its range.
  function automatic logic [31:0] extend_val(logic [31:0] raw, int n, logic sg);
    longint v;
    v = longint'(raw) & ((64'd1 << (8 * n)) - 1);
    if (sg && n < 4 && v >= longint'(64'd1 << (8 * n - 1)))
      v = v - longint'(64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic model_err(logic [1:0] sz, logic [31:0] a);
    if (nbytes(sz) == 0) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  // Apply one request to the reference; returns expected data/err/latency.
  task automatic model_txn(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] ed, output logic ee, output int el);
    logic [31:0] raw;
    ee = model_err(sz, a);
    ed = '0;
    if (ee) el = 1;
    else if (w) begin
      el = 2;
      for (int k = 0; k < nbytes(sz); k++) ref_mem[8'(a[7:0] + k)] = wd[8*k +: 8];
    end else begin
      el = 3;
      raw = '0;
      for (int k = 0; k < nbytes(sz); k++) raw[8*k +: 8] = ref_mem[8'(a[7:0] + k)];
      ed = extend_val(raw, nbytes(sz), sg);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // One full handshake on the latency-1 instance. During 'hold' cycles the
  // response is left unconsumed while a stray store is offered.
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rdata, output logic rerr, output int lat,
                        output int wrens, output logic [1:0] wmode, output logic [31:0] waddr);
    int guard;
    lat = 0; wrens = 0; wmode = 2'b00; waddr = '0; guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_wren) begin wrens++; wmode = mem_mode; waddr = mem_address; end
      if (resp_valid) begin lat = n; break; end
    end
    rdata = resp_data; rerr = resp_err;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h40;
      @(negedge clk);
      check("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_resp_data", resp_data, rdata);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check("hold_no_wren", {31'b0, mem_wren}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("post_resp_valid_low", {31'b0, resp_valid}, 32'd0);
    check("post_req_ready_high", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic run_and_check(input string tag, input logic w, input logic [1:0] sz,
                               input logic sg, input logic [31:0] a, input logic [31:0] wd,
                               input int hold, input logic [31:0] ed, input logic ee,
                               input int el);
    logic [31:0] rd, waddr;
    logic        re;
    logic [1:0]  wmode;
    int          lat, wrens;
    do_txn(w, sz, sg, a, wd, hold, rd, re, lat, wrens, wmode, waddr);
    $display("[TB] %s w=%0d sz=%0d sg=%0d addr=%h wdata=%h -> data=%h err=%0d lat=%0d wren=%0d",
             tag, w, sz, sg, a, wd, rd, re, lat, wrens);
    check({tag, "_latency"}, lat, el);
    check({tag, "_err"}, {31'b0, re}, {31'b0, ee});
    check({tag, "_data"}, rd, ed);
    check({tag, "_wren_pulses"}, wrens, (w && !ee) ? 32'd1 : 32'd0);
    if (wrens > 0) begin
      check({tag, "_wren_mode"}, {30'b0, wmode}, {30'b0, sz});
      check({tag, "_wren_addr"}, waddr, a);
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] ed, rd3;
    logic        ee;
    int          el, lat3, guard;

    for (int i = 0; i < 256; i++) begin
      mem_bytes[i] = 8'($urandom);
      ref_mem[i]   = mem_bytes[i];
    end

    vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1'b0, 2};
    vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h03, 32'h000000D5, 0, 32'h0,        1'b0, 2};
    vecs[2]  = '{1'b0, 2'b10, 1'b1, 32'h03, 32'h0,        0, 32'hFFFFFFD5, 1'b0, 3};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h03, 32'h0,        0, 32'h000000D5, 1'b0, 3};
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h06, 32'h00008001, 0, 32'h0,        1'b0, 2};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h08, 32'hAAAA1234, 0, 32'h0,        1'b0, 2};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h06, 32'h0,        4, 32'hFFFF8001, 1'b0, 3};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h06, 32'h0,        0, 32'h00008001, 1'b0, 3};
    vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        0, 32'h0,        1'b1, 1};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h05, 32'h0,        0, 32'h0,        1'b1, 1};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        0, 32'h0,        1'b1, 1};
    vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h02, 32'h55555555, 2, 32'h0,        1'b1, 1};
    vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        0, 32'hDEADBEEF, 1'b0, 3};
    vecs[13] = '{1'b0, 2'b10, 1'b1, 32'h11, 32'h0,        0, 32'hFFFFFFBE, 1'b0, 3};
    vecs[14] = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        4, 32'hFFFFDEAD, 1'b0, 3};
    vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        0, 32'h0000DEAD, 1'b0, 3};

    // Reset state, observed while reset is still asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset_resp_err", {31'b0, resp_err}, 32'd0);
    check("reset_resp_data", resp_data, 32'd0);
    check("reset_mem_wren", {31'b0, mem_wren}, 32'd0);
    check("reset_mem_address", mem_address, 32'd0);
    check("reset_mem_raw_data", mem_raw_data, 32'd0);
    check("reset_mem_mode", {30'b0, mem_mode}, 32'd0);
    rst = 1'b0;

    // Directed table; stores also update the reference memory.
    for (int i = 0; i < 16; i++) begin
      model_txn(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, ed, ee, el);
      run_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].sg,
                    vecs[i].a, vecs[i].wd, vecs[i].hold,
                    vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      w  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((nbytes(sz) > 0) ? 32'(nbytes(sz) - 1) : 32'd0);
      wd = $urandom;
      model_txn(w, sz, sg, a, wd, ed, ee, el);
      run_and_check($sformatf("rnd%0d", i), w, sz, sg, a, wd, $urandom_range(0, 2), ed, ee, el);
    end

    // Reset during a store's ISSUE cycle: write strobe drops immediately,
    // nothing is written and no response appears.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h30;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk); #2;
    req_valid = 1'b0;
    check("abort_wren_in_issue", {31'b0, mem_wren}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_wren_dropped", {31'b0, mem_wren}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int n = 0; n < 4; n++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      check("abort_no_response", seen, 32'd0);
    end
    $display("[TB] abort store @30 by reset");
    model_txn(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, ed, ee, el);
    run_and_check("after_abort", 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 0, ed, ee, el);

    // MEM_LATENCY=3: load response at accept+5, data sampled at the right edge.
    for (int t = 0; t < 2; t++) begin
      logic [1:0]  sz3;
      logic        sg3;
      logic [31:0] a3;
      sz3 = (t == 0) ? 2'b10 : 2'b01;
      sg3 = (t == 0);
      a3  = (t == 0) ? 32'h21 : 32'h44;
      lat3 = 0; guard = 0;
      @(negedge clk);
      while (!req_ready_3 && guard < 20) begin @(negedge clk); guard++; end
      req_valid_3 = 1'b1; req_size_3 = sz3; req_signed_3 = sg3; req_addr_3 = a3;
      @(posedge clk); #1;
      req_valid_3 = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (resp_valid_3) begin lat3 = n; break; end
      end
      rd3 = resp_data_3;
      $display("[TB] lat3 load sz=%0d sg=%0d addr=%h -> data=%h err=%0d lat=%0d",
               sz3, sg3, a3, rd3, resp_err_3, lat3);
      check("lat3_latency", lat3, 32'd5);
      check("lat3_data", rd3, extend_val(pattern3(a3), nbytes(sz3), sg3));
      check("lat3_err", {31'b0, resp_err_3}, 32'd0);
      resp_ready_3 = 1'b1;
      @(posedge clk); #1;
      resp_ready_3 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
